// File: rtl/imem_fetch_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_e  : sequencer state (RUN / HALTED / FAULT)
//   - IMEM_DEPTH/BITS: default instruction memory geometry
//   - BYTES_PER_WORD : bytes covered by one instruction word
//   - WORD_SHIFT     : byte-PC to word-index shift amount
//   - word_shift_of  : same shift for a non-default word width
// -----------------------------------------------------------------------------
package imem_fetch_pkg;

    localparam int IMEM_DEPTH     = 32;
    localparam int IMEM_BITS      = 64;
    localparam int BYTES_PER_WORD = IMEM_BITS / 8;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_e;

    function automatic int word_shift_of(input int bits);
        return $clog2(bits / 8);
    endfunction

endpackage

// File: rtl/imem_fetch_fifo.sv
// -----------------------------------------------------------------------------
// imem_fetch_fifo
// Two-entry output FIFO holding (instruction word, byte PC) pairs between the
// memory return path and decode. Push and pop may happen in the same cycle;
// flush empties it and takes priority over a simultaneous push/pop.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_push, i_push_data,
//   i_push_pc             : write one entry
//   i_pop                 : remove the head entry (ignored when empty)
//   i_flush               : discard all entries
//   o_head_data, o_head_pc: head entry
//   o_count               : number of stored entries (0..2)
//   o_valid               : FIFO non-empty
// -----------------------------------------------------------------------------
module imem_fetch_fifo #(
    parameter int BITS = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [BITS-1:0] i_push_data,
    input  logic [PC_W-1:0] i_push_pc,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [BITS-1:0] o_head_data,
    output logic [PC_W-1:0] o_head_pc,
    output logic [1:0]      o_count,
    output logic            o_valid
);

    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            w_do_push;
    logic            w_do_pop;
    logic [BITS-1:0] w_ent_data [2];
    logic [PC_W-1:0] w_ent_pc   [2];

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [BITS-1:0] r_data;
            logic [PC_W-1:0] r_pc;
            logic            w_sel;

            assign w_sel = w_do_push && (int'(r_wr_ptr) == gi);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_pc   <= '0;
                end else if (w_sel) begin
                    r_data <= i_push_data;
                    r_pc   <= i_push_pc;
                end
            end

            assign w_ent_data[gi] = r_data;
            assign w_ent_pc[gi]   = r_pc;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_head_data = w_ent_data[r_rd_ptr];
    assign o_head_pc   = w_ent_pc[r_rd_ptr];
    assign o_count     = r_count;
    assign o_valid     = (r_count != 2'd0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for a synchronous-read instruction memory. Owns the fetch PC,
// issues at most one word address per cycle, tags each read with an epoch bit
// so that reads outstanding across a redirect are discarded, and delivers words
// to decode through a valid/ready handshake backed by a 2-entry FIFO.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   address                    : word address to instruction memory
//   readData                   : memory data, valid the cycle after address
//   inst_valid/inst_ready      : decode handshake
//   inst_data, inst_pc         : head instruction word and its byte PC
//   redirect_valid/redirect_pc : one-cycle branch/jump redirect
//   halt                       : level, stops new fetches while high
//   fault                      : sticky out-of-range / misaligned fetch flag
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int              DEPTH    = IMEM_DEPTH,
    parameter int              BITS     = IMEM_BITS,
    parameter int              ADDR_W   = 6,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] address,
    input  logic [BITS-1:0]   readData,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [BITS-1:0]   inst_data,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    output logic              fault
);

    localparam int L_BYTES = (BITS == IMEM_BITS) ? BYTES_PER_WORD : BITS / 8;
    localparam int L_SHIFT = (BITS == IMEM_BITS) ? WORD_SHIFT : word_shift_of(BITS);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_tag_pc;
    logic            r_epoch;
    logic            r_tag_epoch;
    logic            r_inflight;
    logic            r_fault;

    logic [PC_W-1:0] w_index;
    logic            w_out_of_range;
    logic            w_misaligned;
    logic            w_bad_pc;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_fifo_valid;
    logic [1:0]      w_fifo_count;
    logic [2:0]      w_occupancy;

    // Range check is done on the full index, before truncation to ADDR_W.
    assign w_index        = r_fetch_pc >> L_SHIFT;
    assign w_out_of_range = (w_index >= PC_W'(DEPTH));
    assign w_misaligned   = (r_fetch_pc[L_SHIFT-1:0] != '0);
    assign w_bad_pc       = w_out_of_range || w_misaligned;
    assign address        = w_index[ADDR_W-1:0];

    assign w_pop  = w_fifo_valid && inst_ready;
    // A returning read is kept only if no redirect happened since it issued.
    assign w_push = r_inflight && (r_tag_epoch == r_epoch);

    // Slots committed after this edge: buffered + outstanding, minus the word
    // leaving this cycle. Crediting the pop is what allows one word per cycle
    // while still never committing more than the two FIFO slots.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_issue = (r_state == ST_RUN) && !redirect_valid && !halt &&
                     !w_bad_pc && (w_occupancy < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_fetch_pc  <= RESET_PC;
            r_tag_pc    <= '0;
            r_epoch     <= 1'b0;
            r_tag_epoch <= 1'b0;
            r_inflight  <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_epoch <= r_epoch;
                r_tag_pc    <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + PC_W'(L_BYTES);
            end

            // Redirect overrides halt entry and fault detection in the same cycle.
            if (redirect_valid) begin
                r_epoch    <= ~r_epoch;
                r_fetch_pc <= redirect_pc;
                r_fault    <= 1'b0;
                r_state    <= halt ? ST_HALTED : ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (halt) begin
                            r_state <= ST_HALTED;
                        end else if (w_bad_pc) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (!halt) r_state <= ST_RUN;
                    end
                    ST_FAULT: begin
                        r_state <= ST_FAULT;
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    imem_fetch_fifo #(
        .BITS (BITS),
        .PC_W (PC_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (readData),
        .i_push_pc   (r_tag_pc),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head_data (inst_data),
        .o_head_pc   (inst_pc),
        .o_count     (w_fifo_count),
        .o_valid     (w_fifo_valid)
    );

    assign inst_valid = w_fifo_valid;
    assign fault      = r_fault;

endmodule
